// File: rtl/serv_fetch_ctrl.sv
// Instruction fetch sequencer: one Wishbone ibus read per request, one-entry word buffer toward decode.
// Latency: request to cyc 1 cycle; ack to earliest decode load 1 cycle; decode load to next accept 1 cycle.
// Backpressure: a buffered word waits in FULL until i_dec_ready; requests outside IDLE are ignored, not queued.
module serv_fetch_ctrl #(
  parameter bit WITH_TIMEOUT = 1'b1,
  parameter int TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  input  logic        i_dec_ready,
  output logic        o_busy,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  input  logic        i_ibus_err,
  output logic [29:0] o_dec_rdt,
  output logic        o_dec_en,
  output logic        o_fetch_err,
  output logic [1:0]  o_err_cause
);

  // BUSY wants the result, DRAIN only waits for the bus to finish, FULL holds a word for decode.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       capture;
  logic       err_set;
  logic [1:0] cause_nxt;
  logic       bus_done;
  logic       timeout;

  // The two low data bits are always 2'b11 for 32-bit instructions, so decode never sees them.
  logic unused_rdt_lsb;
  assign unused_rdt_lsb = &{1'b0, i_ibus_rdt[1:0]};

  // The bus cycle is held for both BUSY and DRAIN so a cycle is never abandoned mid-transfer.
  assign o_ibus_cyc = (state == S_BUSY) || (state == S_DRAIN);
  assign o_busy     = (state != S_IDLE);
  assign bus_done   = i_ibus_ack | i_ibus_err;
  assign o_dec_en   = (state == S_FULL) && i_dec_ready && !i_flush;

  generate
    if (WITH_TIMEOUT) begin : g_timeout
      logic [TIMEOUT_W-1:0] wait_cnt;

      // Count bus cycles that pass without a response; restart on every accepted request.
      always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
          wait_cnt <= '0;
        end else if (accept) begin
          wait_cnt <= '0;
        end else if (o_ibus_cyc && !bus_done) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end

      // A response arriving in the final counted cycle still wins over the timeout.
      assign timeout = o_ibus_cyc && !bus_done && (wait_cnt == {TIMEOUT_W{1'b1}});
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  // State register; reset drops cyc immediately through the state decode.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    cause_nxt = 2'b00;
    case (state)
      S_IDLE: begin
        if (i_fetch_req) begin
          if (i_pc[1:0] == 2'b00) begin
            accept    = 1'b1;
            state_nxt = S_BUSY;
          end else begin
            err_set   = 1'b1;
            cause_nxt = CAUSE_MISALIGN;
          end
        end
      end
      S_BUSY: begin
        if (bus_done) begin
          state_nxt = S_IDLE;
          // A flush in the response cycle discards the result and any error silently.
          if (!i_flush) begin
            if (i_ibus_err) begin
              err_set   = 1'b1;
              cause_nxt = CAUSE_BUSERR;
            end else begin
              capture   = 1'b1;
              state_nxt = S_FULL;
            end
          end
        end else if (timeout) begin
          state_nxt = S_IDLE;
          if (!i_flush) begin
            err_set   = 1'b1;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end else if (i_flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus_done || timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_FULL: begin
        if (i_flush || i_dec_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address latch, instruction buffer and registered error reporting.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_ibus_adr  <= 32'd0;
      o_dec_rdt   <= 30'd0;
      o_fetch_err <= 1'b0;
      o_err_cause <= 2'b00;
    end else begin
      o_fetch_err <= err_set;
      if (err_set) begin
        o_err_cause <= cause_nxt;
      end
      if (accept) begin
        o_ibus_adr <= i_pc;
      end
      if (capture) begin
        o_dec_rdt <= i_ibus_rdt[31:2];
      end
    end
  end

endmodule

// File: tb/tb_serv_fetch_ctrl.sv
// Bench for serv_fetch_ctrl: transaction-level reference model, randomized fetch scenarios.
// Latency: each transaction's expected timing is derived from the request cycle.
// Backpressure: decode readiness is delayed randomly per transaction.
module tb_serv_fetch_ctrl;

  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_req;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_dec_ready;
  logic        o_busy;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic        i_ibus_err;
  logic [29:0] o_dec_rdt;
  logic        o_dec_en;
  logic        o_fetch_err;
  logic [1:0]  o_err_cause;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] last_cause = 2'b00;

  always #5 clk = ~clk;

  serv_fetch_ctrl #(
    .WITH_TIMEOUT(1'b1),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_fetch_req(i_fetch_req),
    .i_pc       (i_pc),
    .i_flush    (i_flush),
    .i_dec_ready(i_dec_ready),
    .o_busy     (o_busy),
    .o_ibus_adr (o_ibus_adr),
    .o_ibus_cyc (o_ibus_cyc),
    .i_ibus_rdt (i_ibus_rdt),
    .i_ibus_ack (i_ibus_ack),
    .i_ibus_err (i_ibus_err),
    .o_dec_rdt  (o_dec_rdt),
    .o_dec_en   (o_dec_en),
    .o_fetch_err(o_fetch_err),
    .o_err_cause(o_err_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_fetch_req = 1'b0;
    i_pc        = 32'd0;
    i_flush     = 1'b0;
    i_dec_ready = 1'b0;
    i_ibus_ack  = 1'b0;
    i_ibus_err  = 1'b0;
    i_ibus_rdt  = 32'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"},   32'(o_ibus_cyc),  32'd0);
    chk({tag, "_busy"},  32'(o_busy),      32'd0);
    chk({tag, "_adr"},   o_ibus_adr,       32'd0);
    chk({tag, "_rdt"},   32'(o_dec_rdt),   32'd0);
    chk({tag, "_en"},    32'(o_dec_en),    32'd0);
    chk({tag, "_err"},   32'(o_fetch_err), 32'd0);
    chk({tag, "_cause"}, 32'(o_err_cause), 32'd0);
  endtask

  // One fetch scenario. Bus slave responds ack_dly cycles into the bus cycle (never if beyond
  // the timeout window); flush_at is a bus-cycle index or -1; decode becomes ready rdy_dly
  // cycles after the word could first be buffered, optionally together with a flush.
  task automatic run_txn(input logic [31:0] pc, input int ack_dly, input bit use_err,
                         input bit err_ack, input int flush_at, input int rdy_dly,
                         input bit flush_full, input logic [31:0] data);
    bit         aligned, timed_out, flushed, exp_full, exp_err, exp_en;
    int         term_j, ncyc, j, k;
    logic [1:0] exp_cause;
    int         obs_cyc = 0, obs_busy = 0, obs_en = 0, obs_err = 0;
    int         en_cyc = -1, err_cyc = -1;
    logic [29:0] en_rdt = '0;
    logic [1:0]  err_cause = 2'b00;
    logic [31:0] adr_obs = 32'd0;
    bit          adr_seen = 1'b0;

    // Reference outcome from the fetch rules.
    aligned   = (pc[1:0] == 2'b00);
    timed_out = (ack_dly > TMAX);
    term_j    = timed_out ? TMAX : ack_dly;
    flushed   = (flush_at >= 0) && (flush_at <= term_j);
    exp_full  = aligned && !timed_out && !flushed && !use_err;
    exp_err   = !aligned || (!flushed && (timed_out || use_err));
    exp_cause = !aligned ? 2'b01 : (timed_out ? 2'b11 : 2'b10);
    exp_en    = exp_full && !flush_full;
    ncyc      = term_j + rdy_dly + 5;

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idle_inputs();
      i_ibus_rdt = $urandom;
      if (c == 0) begin
        i_fetch_req = 1'b1;
        i_pc        = pc;
      end else if (aligned && (c - 1) <= term_j) begin
        j = c - 1;
        // Requests while the fetcher is busy must be ignored.
        i_fetch_req = 1'($urandom_range(0, 1));
        i_pc        = $urandom;
        i_flush     = (j == flush_at);
        if (j == ack_dly) begin
          i_ibus_ack = use_err ? err_ack : 1'b1;
          i_ibus_err = use_err;
          i_ibus_rdt = data;
        end
      end
      if (aligned && c >= term_j + 2) begin
        k = c - term_j - 2;
        i_dec_ready = (k >= rdy_dly);
        i_flush     = flush_full && (k == rdy_dly);
      end
      #1;
      obs_cyc  += int'(o_ibus_cyc);
      obs_busy += int'(o_busy);
      if (o_ibus_cyc && !adr_seen) begin
        adr_obs  = o_ibus_adr;
        adr_seen = 1'b1;
      end
      if (o_dec_en) begin
        obs_en++;
        en_cyc = c;
        en_rdt = o_dec_rdt;
      end
      if (o_fetch_err) begin
        obs_err++;
        err_cyc   = c;
        err_cause = o_err_cause;
      end
    end
    @(negedge clk);
    idle_inputs();

    chk("cyc_cycles",  obs_cyc,  aligned ? term_j + 1 : 0);
    chk("busy_cycles", obs_busy, aligned ? term_j + 1 + (exp_full ? rdy_dly + 1 : 0) : 0);
    chk("dec_en_cnt",  obs_en,   exp_en ? 1 : 0);
    chk("err_cnt",     obs_err,  exp_err ? 1 : 0);
    if (aligned) chk("ibus_adr", adr_obs, pc);
    if (exp_en) begin
      chk("dec_rdt",    32'(en_rdt), 32'(data[31:2]));
      chk("dec_en_cyc", en_cyc,      term_j + 2 + rdy_dly);
    end
    if (exp_full) chk("rdt_hold", 32'(o_dec_rdt), 32'(data[31:2]));
    if (exp_err) begin
      chk("err_cause", 32'(err_cause), 32'(exp_cause));
      chk("err_cyc",   err_cyc,        aligned ? term_j + 2 : 1);
      last_cause = exp_cause;
    end
    chk("cause_held", 32'(o_err_cause), 32'(last_cause));
  endtask

  initial begin
    int ad, tj, fa;
    logic [31:0] pc;

    i_rst = 1'b1;
    idle_inputs();
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    i_rst = 1'b0;

    // Directed scenarios.
    run_txn(32'h0000_0100, 2,  0, 0, -1, 0, 0, 32'h00A0_0093);
    run_txn(32'h0000_0200, 1,  0, 0, -1, 5, 0, 32'h1234_5677);
    run_txn(32'h0000_0102, 2,  0, 0, -1, 0, 0, 32'hDEAD_BEEF);
    run_txn(32'h0000_0300, 3,  0, 0,  0, 0, 0, 32'hCAFE_F00F);
    run_txn(32'h0000_0400, 2,  1, 1, -1, 0, 0, 32'h0BAD_0BAD);
    run_txn(32'h0000_0500, 20, 0, 0, -1, 0, 0, 32'h5555_5555);
    run_txn(32'h0000_0600, 15, 0, 0, -1, 1, 0, 32'hA5A5_A5A7);
    run_txn(32'h0000_0700, 20, 0, 0,  3, 0, 0, 32'h7777_7777);
    run_txn(32'h0000_0800, 1,  0, 0, -1, 2, 1, 32'h8888_8888);
    run_txn(32'h0000_0903, 0,  0, 0, -1, 0, 0, 32'h9999_9999);
    run_txn(32'h0000_0A00, 0,  1, 0, -1, 0, 0, 32'hAAAA_AAAA);

    // Reset asserted mid-bus-cycle after a word and an error cause have been recorded.
    @(negedge clk);
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0B00;
    @(negedge clk);
    i_fetch_req = 1'b0;
    #1;
    chk("pre_rst_cyc", 32'(o_ibus_cyc), 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    i_rst = 1'b0;
    idle_inputs();
    last_cause = 2'b00;

    // Randomized scenarios.
    for (int n = 0; n < 250; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
      ad = ($urandom_range(0, 6) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 5);
      tj = (ad > TMAX) ? TMAX : ad;
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tj) : -1;
      run_txn(pc, ad, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), fa,
              $urandom_range(0, 6), ($urandom_range(0, 6) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
